vga_sync_receiver: RTL and testbench

Recovers VGA raster timing from an incoming `h_synch`/`v_synch` pair: measures line length (pixel strobes per line) and frame length (lines per frame), tracks the current position, and declares lock after a configurable run of identical frames. It sits at the consuming end of the VGA timing link, for example on an input capture path, a loopback self-check of the display controller, or an overlay block slaved to an external raster. It drives no pixels itself.

---
 rtl/vga_sync_receiver.sv | 174 +++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// VGA raster timing recovery: measures line/frame length and locks on stable timing.
// Define VGA_RX_ERRCNT_EN to implement the saturating err_cnt; otherwise it reads 0.
module vga_sync_receiver #(
  parameter int CORDW       = 16,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             h_synch,
  input  logic             v_synch,
  output logic [CORDW-1:0] h_cnt,
  output logic [CORDW-1:0] v_cnt,
  output logic [CORDW-1:0] h_total,
  output logic [CORDW-1:0] v_total,
  output logic             locked,
  output logic             frame_start,
  output logic [7:0]       err_cnt
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [CORDW-1:0] CMAX  = '1;
  localparam logic [CORDW-1:0] CMAX1 = {{(CORDW-1){1'b1}}, 1'b0};
  localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             vs_pend_q, vs_pend_d;
  logic             line_err_q, line_err_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       match_q, match_d;
  logic [CORDW-1:0] h_cnt_q, h_cnt_d;
  logic [CORDW-1:0] v_cnt_q, v_cnt_d;
  logic [CORDW-1:0] h_tot_q, h_tot_d;
  logic [CORDW-1:0] v_tot_q, v_tot_d;
  logic             fs_q, fs_d;
  logic             locked_q, locked_d;

  logic             hs_fall, vs_fall, fs;
  logic             sync_lost, match;
  logic [CORDW-1:0] line_len, frame_len;
  logic [3:0]       m_inc;

  always_comb begin
    hs_fall   = enb & hs_q & ~h_synch;
    vs_fall   = enb & vs_q & ~v_synch;
    fs        = hs_fall & (vs_pend_q | vs_fall);
    line_len  = h_cnt_q + CORDW'(1);
    frame_len = v_cnt_q + CORDW'(1);
    m_inc     = match_q + 4'd1;
    match     = (line_len == h_tot_q) && (frame_len == v_tot_q) && !line_err_q;
    // Fires only on the step into saturation, so it is counted once.
    sync_lost = enb & ((~hs_fall & (h_cnt_q == CMAX1)) |
                       (hs_fall & ~fs & (v_cnt_q == CMAX1)));

    hs_d       = hs_q;
    vs_d       = vs_q;
    vs_pend_d  = vs_pend_q;
    line_err_d = line_err_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    state_d    = state_q;
    match_d    = match_q;
    h_tot_d    = h_tot_q;
    v_tot_d    = v_tot_q;

    if (enb) begin
      hs_d = h_synch;
      vs_d = v_synch;
      if (fs) vs_pend_d = 1'b0;
      else if (vs_fall) vs_pend_d = 1'b1;
      if (hs_fall) h_cnt_d = '0;
      else if (h_cnt_q != CMAX) h_cnt_d = line_len;
      if (fs) v_cnt_d = '0;
      else if (hs_fall && v_cnt_q != CMAX) v_cnt_d = frame_len;
      if (fs) line_err_d = 1'b0;
      else if (hs_fall && line_len != h_tot_q) line_err_d = 1'b1;
    end

    if (sync_lost) begin
      state_d = ST_SEARCH;
      h_tot_d = '0;
      v_tot_d = '0;
      match_d = '0;
    end else if (fs) begin
      unique case (1'b1)
        state_q == ST_ACQUIRE: begin
          if (match) begin
            match_d = m_inc;
            if (m_inc == LOCK_N) state_d = ST_LOCKED;
          end else begin
            h_tot_d = line_len;
            v_tot_d = frame_len;
            match_d = '0;
          end
        end
        state_q == ST_LOCKED: begin
          if (!match) begin
            state_d = ST_ACQUIRE;
            h_tot_d = line_len;
            v_tot_d = frame_len;
            match_d = '0;
          end
        end
        default: state_d = ST_ACQUIRE;
      endcase
    end

    fs_d     = fs;
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      vs_pend_q  <= 1'b0;
      line_err_q <= 1'b0;
      state_q    <= ST_SEARCH;
      match_q    <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      h_tot_q    <= '0;
      v_tot_q    <= '0;
      fs_q       <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      vs_pend_q  <= vs_pend_d;
      line_err_q <= line_err_d;
      state_q    <= state_d;
      match_q    <= match_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      h_tot_q    <= h_tot_d;
      v_tot_q    <= v_tot_d;
      fs_q       <= fs_d;
      locked_q   <= locked_d;
    end
  end

`ifdef VGA_RX_ERRCNT_EN
  logic [7:0] err_q, err_d;
  logic       err_inc;

  always_comb begin
    err_inc = sync_lost |
              (fs & (state_q == ST_LOCKED) & ~match);
    err_d   = err_q;
    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign h_total     = h_tot_q;
  assign v_total     = v_tot_q;
  assign locked      = locked_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver: 10x6 raster, LOCK_FRAMES=2.
module tb_vga_sync_receiver;

`ifdef VGA_RX_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        enb;
  logic        h_synch;
  logic        v_synch;
  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic [15:0] h_total;
  logic [15:0] v_total;
  logic        locked;
  logic        frame_start;
  logic [7:0]  err_cnt;

  int tests;
  int fails;
  int cyc;
  int fs_n;
  int fs_cyc;
  int fs_gap;
  int fs_run;
  int run_max;
  int hmax;
  int vmax;
  logic fs_locked;

  vga_sync_receiver #(.CORDW(16), .LOCK_FRAMES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enb(enb),
    .h_synch(h_synch),
    .v_synch(v_synch),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .h_total(h_total),
    .v_total(v_total),
    .locked(locked),
    .frame_start(frame_start),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_err(input int n);
    return ERR_EN ? 8'(n) : 8'd0;
  endfunction

  task automatic tick(input logic h, input logic v, input logic e);
    @(negedge clk);
    h_synch = h;
    v_synch = v;
    enb = e;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_start) begin
      fs_n++;
      fs_gap = cyc - fs_cyc;
      fs_cyc = cyc;
      fs_locked = locked;
      fs_run++;
      if (fs_run > run_max) run_max = fs_run;
    end else begin
      fs_run = 0;
    end
    if (int'(h_cnt) > hmax) hmax = int'(h_cnt);
    if (int'(v_cnt) > vmax) vmax = int'(v_cnt);
  endtask

  task automatic send_sample(input logic h, input logic v, input bit half);
    tick(h, v, 1'b1);
    if (half) tick(h, v, 1'b0);
  endtask

  task automatic send_line(input int len, input bit vlow, input bit half);
    for (int s = 0; s < len; s++)
      send_sample(!(s == len - 3 || s == len - 2), !vlow, half);
  endtask

  task automatic send_frame(input int stretch, input bit half);
    for (int l = 0; l < 6; l++)
      send_line((l == stretch) ? 11 : 10, l == 4, half);
  endtask

  task automatic clr_stats();
    hmax = 0;
    vmax = 0;
    run_max = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    tests++;
    if ({h_cnt, v_cnt, h_total, v_total, locked, frame_start, err_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got h=%0d v=%0d ht=%0d vt=%0d lk=%b fs=%b err=%0d, want all 0",
               h_cnt, v_cnt, h_total, v_total, locked, frame_start, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    tests++;
    if (h_cnt !== 16'd0) begin
      fails++;
      $display("FAIL enb_low_hold: h_cnt=%0d want 0", h_cnt);
    end
    fs_n = 0;
    repeat (100) tick(1'b1, 1'b1, 1'b1);
    tests++;
    if (fs_n != 0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_fs: fs=%0d locked=%b want 0/0", fs_n, locked);
    end
    tests++;
    if (h_cnt !== 16'd100 || v_cnt !== 16'd0) begin
      fails++;
      $display("FAIL idle_counts: h=%0d v=%0d want 100/0", h_cnt, v_cnt);
    end
  endtask

  task automatic test_lock();
    fs_n = 0;
    for (int k = 1; k <= 6; k++) begin
      send_frame(-1, 1'b0);
      if (k == 2) clr_stats();
      if (k == 3) begin
        tests++;
        if (locked !== 1'b0 || fs_locked !== 1'b0) begin
          fails++;
          $display("FAIL lock_early: locked=%b at fs3 want 0", locked);
        end
      end
      if (k == 4) begin
        tests++;
        if (fs_locked !== 1'b1 || fs_n != 4) begin
          fails++;
          $display("FAIL lock_at_fs4: locked_at_fs=%b fs=%0d want 1/4", fs_locked, fs_n);
        end
      end
    end
    tests++;
    if (fs_gap != 60 || run_max != 1) begin
      fails++;
      $display("FAIL fs_period: gap=%0d width=%0d want 60/1", fs_gap, run_max);
    end
    tests++;
    if (hmax != 9 || vmax != 5) begin
      fails++;
      $display("FAIL count_range: hmax=%0d vmax=%0d want 9/5", hmax, vmax);
    end
    tests++;
    if (h_total !== 16'd10 || v_total !== 16'd6 || locked !== 1'b1 || err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL lock_totals: ht=%0d vt=%0d lk=%b err=%0d want 10/6/1/0",
               h_total, v_total, locked, err_cnt);
    end
  endtask

  task automatic test_stretch();
    send_frame(1, 1'b0);
    tests++;
    if (locked !== 1'b0 || fs_locked !== 1'b0 || err_cnt !== exp_err(1)) begin
      fails++;
      $display("FAIL stretch_drop: lk=%b err=%0d want 0/%0d", locked, err_cnt, exp_err(1));
    end
    tests++;
    if (h_total !== 16'd10 || v_total !== 16'd6) begin
      fails++;
      $display("FAIL stretch_reload: ht=%0d vt=%0d want 10/6", h_total, v_total);
    end
    send_frame(-1, 1'b0);
    tests++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL stretch_relock_early: lk=%b want 0", locked);
    end
    send_frame(-1, 1'b0);
    tests++;
    if (locked !== 1'b1 || fs_locked !== 1'b1) begin
      fails++;
      $display("FAIL stretch_relock: lk=%b want 1", locked);
    end
  endtask

  task automatic test_hs_lost();
    logic prev_lk;
    bit   hit;
    prev_lk = locked;
    hit = 1'b0;
    for (int i = 0; i < 70000 && !hit; i++) begin
      prev_lk = locked;
      tick(1'b1, 1'b1, 1'b1);
      if (h_cnt == 16'hFFFF) hit = 1'b1;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL hs_lost_sat: h_cnt=%0d want 65535 within bound", h_cnt);
    end
    tests++;
    if (prev_lk !== 1'b1 || locked !== 1'b0) begin
      fails++;
      $display("FAIL hs_lost_unlock: before=%b after=%b want 1/0", prev_lk, locked);
    end
    tests++;
    if (h_total !== 16'd0 || v_total !== 16'd0 || err_cnt !== exp_err(2)) begin
      fails++;
      $display("FAIL hs_lost_clear: ht=%0d vt=%0d err=%0d want 0/0/%0d",
               h_total, v_total, err_cnt, exp_err(2));
    end
    repeat (5) tick(1'b1, 1'b1, 1'b1);
    tests++;
    if (h_cnt !== 16'hFFFF || err_cnt !== exp_err(2)) begin
      fails++;
      $display("FAIL hs_lost_hold: h=%0d err=%0d want 65535/%0d", h_cnt, err_cnt, exp_err(2));
    end
  endtask

  task automatic test_half_rate();
    fs_n = 0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(-1, 1'b1);
      if (k == 2) clr_stats();
      if (k == 3) begin
        tests++;
        if (locked !== 1'b0) begin
          fails++;
          $display("FAIL half_lock_early: lk=%b want 0", locked);
        end
      end
      if (k == 4) begin
        tests++;
        if (locked !== 1'b1 || fs_locked !== 1'b1) begin
          fails++;
          $display("FAIL half_lock: lk=%b want 1", locked);
        end
      end
    end
    tests++;
    if (fs_gap != 120 || run_max != 1 || hmax != 9 || vmax != 5) begin
      fails++;
      $display("FAIL half_timing: gap=%0d w=%0d hmax=%0d vmax=%0d want 120/1/9/5",
               fs_gap, run_max, hmax, vmax);
    end
    tests++;
    if (h_total !== 16'd10 || v_total !== 16'd6 || err_cnt !== exp_err(2)) begin
      fails++;
      $display("FAIL half_totals: ht=%0d vt=%0d err=%0d want 10/6/%0d",
               h_total, v_total, err_cnt, exp_err(2));
    end
  endtask

  task automatic test_reset_mid();
    logic lk_before;
    send_line(10, 1'b0, 1'b0);
    send_line(10, 1'b0, 1'b0);
    lk_before = locked;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (lk_before !== 1'b1 ||
        {h_cnt, v_cnt, h_total, v_total, locked, frame_start, err_cnt} !== '0) begin
      fails++;
      $display("FAIL async_reset: before=%b h=%0d v=%0d ht=%0d vt=%0d lk=%b err=%0d want 1 then all 0",
               lk_before, h_cnt, v_cnt, h_total, v_total, locked, err_cnt);
    end
    repeat (2) tick(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fs_n = 0;
    for (int k = 1; k <= 4; k++) begin
      send_frame(-1, 1'b0);
      if (k == 3) begin
        tests++;
        if (locked !== 1'b0) begin
          fails++;
          $display("FAIL relock_early: lk=%b want 0", locked);
        end
      end
    end
    tests++;
    if (locked !== 1'b1 || fs_n != 4 || err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL relock_after_reset: lk=%b fs=%0d err=%0d want 1/4/0", locked, fs_n, err_cnt);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    fs_n = 0;
    fs_cyc = 0;
    fs_gap = 0;
    fs_run = 0;
    fs_locked = 1'b0;
    clr_stats();
    rst_n = 1'b0;
    enb = 1'b0;
    h_synch = 1'b1;
    v_synch = 1'b1;
    test_reset();
    test_lock();
    test_stretch();
    test_hs_lost();
    test_half_rate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
